// File: rtl/banked_register_file_sb.sv
// banked_register_file_sb
// NREG general registers with three combinational read ports, one write port,
// a dedicated PC register (hazard hold, branch write, branch-and-link capture),
// write-first bypass on every read port and a pending-write scoreboard whose
// ready flags feed the hazard unit in the ID stage.
module banked_register_file_sb #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 4,
  parameter  int PC_IDX = 15,
  parameter  int LR_IDX = 14,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [ADDR_W-1:0] SD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  output logic              PA_RDY,
  output logic              PB_RDY,
  output logic              PD_RDY,
  input  logic [ADDR_W-1:0] C,
  input  logic [DATA_W-1:0] PW,
  input  logic              RFLd,
  input  logic [DATA_W-1:0] PCin,
  input  logic              HZPCld,
  input  logic              BL,
  output logic [DATA_W-1:0] PCout,
  input  logic              ISS_EN,
  input  logic [ADDR_W-1:0] ISS_ADDR,
  output logic [NREG-1:0]   PEND
);

  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LR_A    = ADDR_W'(LR_IDX);
  localparam logic [NREG-1:0]   ONE_BIT = {{(NREG-1){1'b0}}, 1'b1};
  localparam int                NPORT   = 3;

  // Architectural state. The PC slot of regs_r is never written; the PC
  // lives in pc_r so that its hold/load rules stay separate from the file.
  logic [DATA_W-1:0] regs_r [NREG];
  logic [DATA_W-1:0] pc_r;
  logic [NREG-1:0]   pend_r;

  // Decoded control.
  logic              link_s;
  logic              wr_gen_s;
  logic              wr_pc_s;
  logic [NREG-1:0]   clr_mask_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   pend_nxt_s;

  // Read port bundles: index 0 = A, 1 = B, 2 = D.
  logic [ADDR_W-1:0] sel_s [NPORT];
  logic [DATA_W-1:0] rd_s  [NPORT];
  logic              rdy_s [NPORT];

  // Link only happens when the pipeline is advancing; a stalled BL is dropped.
  assign link_s   = BL & HZPCld;
  assign wr_gen_s = RFLd & (C != PC_A);
  assign wr_pc_s  = RFLd & (C == PC_A);

  assign sel_s[0] = SA;
  assign sel_s[1] = SB;
  assign sel_s[2] = SD;

  assign PA     = rd_s[0];
  assign PB     = rd_s[1];
  assign PD     = rd_s[2];
  assign PA_RDY = rdy_s[0];
  assign PB_RDY = rdy_s[1];
  assign PD_RDY = rdy_s[2];

  assign PCout = pc_r;
  assign PEND  = pend_r;

  // General register file update; the link capture into LR beats a same-edge write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (link_s && (ADDR_W'(i) == LR_A)) begin
          regs_r[i] <= pc_r;
        end else if (wr_gen_s && (C == ADDR_W'(i))) begin
          regs_r[i] <= PW;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // PC register: a branch write overrides a stall, otherwise load or hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_r <= '0;
    end else if (wr_pc_s) begin
      pc_r <= PW;
    end else if (HZPCld) begin
      pc_r <= PCin;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Scoreboard next state: clear on write-back, then a new reservation wins.
  always_comb begin
    clr_mask_s = '0;
    set_mask_s = '0;
    if (RFLd) begin
      clr_mask_s = ONE_BIT << C;
    end else begin
      clr_mask_s = '0;
    end
    if (ISS_EN && (ISS_ADDR != PC_A)) begin
      set_mask_s = ONE_BIT << ISS_ADDR;
    end else begin
      set_mask_s = '0;
    end
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~(ONE_BIT << PC_A);
  end

  // Scoreboard register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Read muxes with write-first bypass; PC reads never see PW.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_s[p]  = '0;
      rdy_s[p] = 1'b1;
      if (RFLd && (C == sel_s[p]) && (sel_s[p] != PC_A)) begin
        rd_s[p] = PW;
      end else if (link_s && (sel_s[p] == LR_A)) begin
        rd_s[p] = pc_r;
      end else if (sel_s[p] == PC_A) begin
        rd_s[p] = pc_r;
      end else begin
        rd_s[p] = regs_r[sel_s[p]];
      end
      rdy_s[p] = ~pend_r[sel_s[p]] | (RFLd & (C == sel_s[p]));
    end
  end

endmodule

// File: tb/tb_banked_register_file_sb.sv
// tb_banked_register_file_sb
// Directed literal checks from the test plan plus a randomized run compared
// every cycle against a behavioural model of the register file.
module tb_banked_register_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [ADDR_W-1:0] SA, SB, SD, C, ISS_ADDR;
  logic [DATA_W-1:0] PA, PB, PD, PW, PCin, PCout;
  logic              PA_RDY, PB_RDY, PD_RDY;
  logic              RFLd, HZPCld, BL, ISS_EN;
  logic [NREG-1:0]   PEND;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  banked_register_file_sb #(
    .DATA_W(32), .ADDR_W(4), .PC_IDX(15), .LR_IDX(14)
  ) dut (
    .CLK(CLK), .RST(RST),
    .SA(SA), .SB(SB), .SD(SD),
    .PA(PA), .PB(PB), .PD(PD),
    .PA_RDY(PA_RDY), .PB_RDY(PB_RDY), .PD_RDY(PD_RDY),
    .C(C), .PW(PW), .RFLd(RFLd),
    .PCin(PCin), .HZPCld(HZPCld), .BL(BL), .PCout(PCout),
    .ISS_EN(ISS_EN), .ISS_ADDR(ISS_ADDR), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: a plain array of registers, a PC and a pending set.
  logic [31:0] m_reg [16];
  logic [31:0] m_pc;
  logic [15:0] m_pend;

  // Model state update on each edge, following the update rules directly.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 32'd0;
      m_pc   <= 32'd0;
      m_pend <= 16'd0;
    end else begin
      if (RFLd && C != 4'd15) m_reg[C] <= PW;
      if (BL && HZPCld) m_reg[14] <= m_pc;      // later assignment wins
      if (RFLd && C == 4'd15) m_pc <= PW;
      else if (HZPCld) m_pc <= PCin;
      m_pend <= (m_pend & ~(RFLd ? (16'd1 << C) : 16'd0))
              | ((ISS_EN && ISS_ADDR != 4'd15) ? (16'd1 << ISS_ADDR) : 16'd0);
    end
  end

  function automatic logic [31:0] exp_read(input logic [3:0] s);
    if (RFLd && C == s && s != 4'd15) return PW;
    if (BL && HZPCld && s == 4'd14) return m_pc;
    if (s == 4'd15) return m_pc;
    return m_reg[s];
  endfunction

  function automatic logic [31:0] exp_rdy(input logic [3:0] s);
    return {31'd0, (!m_pend[s]) || (RFLd && C == s)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, on the falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc PA", PA, exp_read(SA));
      check("cyc PB", PB, exp_read(SB));
      check("cyc PD", PD, exp_read(SD));
      check("cyc PA_RDY", {31'd0, PA_RDY}, exp_rdy(SA));
      check("cyc PB_RDY", {31'd0, PB_RDY}, exp_rdy(SB));
      check("cyc PD_RDY", {31'd0, PD_RDY}, exp_rdy(SD));
      check("cyc PCout", PCout, m_pc);
      check("cyc PEND", {16'd0, PEND}, {16'd0, m_pend});
    end
  end

  task automatic idle();
    SA = 4'd0; SB = 4'd0; SD = 4'd0; C = 4'd0; PW = 32'd0; RFLd = 1'b0;
    PCin = 32'd0; HZPCld = 1'b0; BL = 1'b0; ISS_EN = 1'b0; ISS_ADDR = 4'd0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    #12 RST = 1'b0;
    chk_en = 1'b1;
    tick();

    // Bypass of a general write, then the registered value.
    RFLd = 1'b1; C = 4'd5; PW = 32'hDEAD_BEEF; SA = 4'd5;
    #1 check("bypass PA", PA, 32'hDEAD_BEEF);
    tick();
    RFLd = 1'b0;
    #1 check("stored PA", PA, 32'hDEAD_BEEF);

    // PC sequence, stall, branch write overriding a stall.
    HZPCld = 1'b1; PCin = 32'd4;  tick(); check("pc 4", PCout, 32'd4);
    PCin = 32'd8;  tick(); check("pc 8", PCout, 32'd8);
    PCin = 32'd12; tick(); check("pc 12", PCout, 32'd12);
    HZPCld = 1'b0; PCin = 32'd99; tick(); tick();
    check("pc hold", PCout, 32'd12);
    RFLd = 1'b1; C = 4'd15; PW = 32'h100; SA = 4'd15;
    #1 check("pc read no bypass", PA, 32'd12);
    tick();
    RFLd = 1'b0;
    check("pc branch", PCout, 32'h100);

    // Branch-and-link beats a same-edge LR write.
    RFLd = 1'b1; C = 4'd15; PW = 32'h40; tick();
    RFLd = 1'b1; C = 4'd14; PW = 32'h99; BL = 1'b1; HZPCld = 1'b1; PCin = 32'h44; SA = 4'd14;
    #1 check("lr read bypass", PA, 32'h99);
    tick();
    idle(); SA = 4'd14;
    #1 check("link R14", PA, 32'h40);
    check("pc after link", PCout, 32'h44);
    RFLd = 1'b1; C = 4'd14; PW = 32'h99; BL = 1'b1; HZPCld = 1'b0;
    tick();
    idle(); SA = 4'd14;
    #1 check("stalled BL R14", PA, 32'h99);
    check("stalled BL pc", PCout, 32'h44);

    // Scoreboard set, clear with combinational ready, and set-wins.
    ISS_EN = 1'b1; ISS_ADDR = 4'd7; tick();
    ISS_EN = 1'b0; SB = 4'd7;
    #1 check("pend 7", {16'd0, PEND}, 32'h80);
    check("PB_RDY pending", {31'd0, PB_RDY}, 32'd0);
    RFLd = 1'b1; C = 4'd7; PW = 32'h77;
    #1 check("PB_RDY writeback", {31'd0, PB_RDY}, 32'd1);
    check("PB writeback data", PB, 32'h77);
    tick();
    RFLd = 1'b0;
    check("pend cleared", {16'd0, PEND}, 32'd0);
    ISS_EN = 1'b1; ISS_ADDR = 4'd7; RFLd = 1'b1; C = 4'd7; tick();
    ISS_EN = 1'b0; RFLd = 1'b0;
    check("set wins", {16'd0, PEND}, 32'h80);
    RFLd = 1'b1; C = 4'd7; tick();
    RFLd = 1'b0; ISS_EN = 1'b1; ISS_ADDR = 4'd15; tick();
    ISS_EN = 1'b0;
    check("pend pc ignored", {16'd0, PEND}, 32'd0);

    // Asynchronous reset mid-cycle, and held across an edge.
    RFLd = 1'b1; C = 4'd3; PW = 32'h1234_5678; ISS_EN = 1'b1; ISS_ADDR = 4'd3; tick();
    idle(); SA = 4'd3; HZPCld = 1'b1; PCin = 32'h50;
    #1 check("pre-reset R3", PA, 32'h1234_5678);
    check("pre-reset PA_RDY", {31'd0, PA_RDY}, 32'd0);
    #1 RST = 1'b1;
    #1 check("reset R3", PA, 32'd0);
    check("reset PEND", {16'd0, PEND}, 32'd0);
    check("reset PA_RDY", {31'd0, PA_RDY}, 32'd1);
    check("reset PCout", PCout, 32'd0);
    @(posedge CLK);
    #2 check("reset held PC", PCout, 32'd0);
    RST = 1'b0;
    tick();
    HZPCld = 1'b0;

    // Exhaustive write of indices 0..14, then read on all three ports.
    for (int i = 0; i < 15; i++) begin
      RFLd = 1'b1; C = 4'(i); PW = 32'hC0DE_0000 | (32'(i) * 32'h0000_0111);
      tick();
    end
    RFLd = 1'b0;
    for (int i = 0; i < 15; i++) begin
      SA = 4'(i); SB = 4'((i + 5) % 15); SD = 4'((i + 10) % 15);
      #1;
      check("exh PA", PA, 32'hC0DE_0000 | (32'(i) * 32'h0000_0111));
      check("exh PB", PB, 32'hC0DE_0000 | (32'((i + 5) % 15) * 32'h0000_0111));
      check("exh PD", PD, 32'hC0DE_0000 | (32'((i + 10) % 15) * 32'h0000_0111));
    end
    tick();

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      RST      = ($urandom_range(0, 149) == 0);
      SA       = 4'($urandom_range(0, 15));
      SB       = 4'($urandom_range(0, 15));
      SD       = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      C        = ($urandom_range(0, 3) == 0) ? SA : 4'($urandom_range(0, 15));
      PW       = $urandom;
      RFLd     = ($urandom_range(0, 2) != 0);
      PCin     = $urandom;
      HZPCld   = ($urandom_range(0, 3) != 0);
      BL       = ($urandom_range(0, 4) == 0);
      ISS_EN   = ($urandom_range(0, 1) == 0);
      ISS_ADDR = ($urandom_range(0, 3) == 0) ? C : 4'($urandom_range(0, 15));
      tick();
    end
    RST = 1'b0;
    idle();
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_register_file_sb.md
Name: banked_register_file_sb

Overview:
- Parametrised successor to the PF1 register file: NREG = 2**ADDR_W general registers of DATA_W bits, three combinational read ports (A, B, D) and one write port.
- R[PC_IDX] is a dedicated PC register with hazard-hold and a branch-and-link capture into R[LR_IDX].
- Adds what PF1 lacks: write-first bypass on all read ports, and a per-register pending-write scoreboard with ready flags.
- Sits in the ID stage of the pipelined datapath; the hazard unit consumes the ready flags.

Parameters:
- DATA_W, 32, register and port data width
- ADDR_W, 4, register index width; NREG = 2**ADDR_W
- PC_IDX, 15, index of the PC register
- LR_IDX, 14, index of the link register

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous reset, active-high
- SA, SB, SD  in  ADDR_W  read selects for ports A, B, D
- PA, PB, PD  out  DATA_W  read data
- PA_RDY, PB_RDY, PD_RDY  out  1  selected register has no outstanding write (or is being bypassed)
- C  in  ADDR_W  write index
- PW  in  DATA_W  write data
- RFLd  in  1  write enable
- PCin  in  DATA_W  next sequential PC
- HZPCld  in  1  PC load enable; 0 = stall/hold
- BL  in  1  branch-and-link: capture the current PC into LR
- PCout  out  DATA_W  current PC register value
- ISS_EN  in  1  reserve a destination register (instruction issue)
- ISS_ADDR  in  ADDR_W  register index to reserve
- PEND  out  NREG  scoreboard bit vector, bit i = R[i] write pending

Behaviour:
- Reset (RST=1, asynchronous, takes effect immediately mid-cycle):
  - all registers, the PC and PEND = 0
  - PCout = 0; PA/PB/PD = 0 (or PW when bypassing); all RDY = 1
  - Reset held over clock edges blocks every update.
- General write, at posedge with RFLd=1 and C != PC_IDX: R[C] <= PW. Writes to index C are visible in R one cycle later, or the same cycle through the bypass.
- PC update, at posedge, in priority order:
  1. RFLd=1 and C==PC_IDX: PC <= PW. This applies even when HZPCld=0; a branch write overrides a stall.
  2. Otherwise, HZPCld=1: PC <= PCin.
  3. Otherwise: PC holds.
- Link, at posedge with BL=1 and HZPCld=1: R[LR_IDX] <= PCout (the pre-edge value).
  - BL with HZPCld=0 is ignored.
  - BL beats a same-cycle RFLd write to LR_IDX (BL is the younger instruction).
- Read, purely combinational, zero latency:
  - Px = PW if RFLd=1, C==Sx and Sx != PC_IDX.
  - Else, Px = PCout if BL=1, HZPCld=1 and Sx==LR_IDX.
  - Else, Px = PCout if Sx==PC_IDX.
  - Else, Px = R[Sx].
  - Reads of PC_IDX never bypass PW; they return the registered PC.
- Scoreboard, at posedge:
  - Set PEND[ISS_ADDR] when ISS_EN=1.
  - Clear PEND[C] when RFLd=1.
  - Same index set and cleared in one cycle: the bit ends set, because the new reservation wins.
  - ISS_EN with ISS_ADDR==PC_IDX is ignored; PEND[PC_IDX] is always 0.
  - Clearing a bit that is not set has no effect (no error).
- Ready: Px_RDY = ~PEND[Sx] | (RFLd & C==Sx). A pending register being written back this cycle reads as ready, with the bypassed data.
- Width: no arithmetic inside the block. PCin is computed externally; all ports are DATA_W with no truncation.

Test Plan:
- Assert RST mid-cycle after R3 = 0x1234_5678 and PEND[3] = 1 → R3 = 0, PEND = 0 and PA_RDY = 1 immediately, before the next edge; PCout = 0.
- RFLd=1, C=5, PW=0xDEAD_BEEF, SA=5, same cycle → PA = 0xDEAD_BEEF before the edge. After the edge with RFLd=0, PA still reads 0xDEAD_BEEF.
- PC sequence:
  - HZPCld=1 with PCin = 4, 8, 12 → PCout = 4, 8, 12.
  - HZPCld=0 for 2 cycles → PCout holds 12.
  - RFLd=1, C=15, PW=0x100 with HZPCld=0 → PCout = 0x100.
- PCout = 0x40, BL=1, HZPCld=1, RFLd=1, C=14, PW=0x99 → R14 = 0x40 after the edge. The same test with HZPCld=0 → R14 = 0x99.
- Scoreboard:
  - ISS_EN=1, ISS_ADDR=7 → PEND = 0x0080; SB=7 gives PB_RDY = 0.
  - Next cycle RFLd=1, C=7 → PB_RDY = 1 combinationally; PEND = 0 after the edge.
  - ISS_EN with ISS_ADDR=7 and RFLd with C=7 in the same cycle → PEND[7] stays 1.
- ISS_EN=1, ISS_ADDR=15 → PEND stays 0. Exhaustive pass writing each index 0-14 with a unique value, then reading all three ports → all values match.
